// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: EX/MEM register, big-endian byte-addressed data memory, MEM/WB register.
// Optional MEMWB_MISALIGN_TRAP_EN: odd word accesses set a sticky flag instead of being aligned down.
module mem_wb_stage #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_alu_result,
    input  logic [15:0] ex_r15_result,
    input  logic [15:0] ex_store_data,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_wrt,
    input  logic        ex_r15_wrt,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wrt,
    input  logic        ex_byte,
    output logic [3:0]  exm_rd,
    output logic        exm_reg_wrt,
    output logic [15:0] exm_result,
    output logic        wb_reg_wrt,
    output logic        wb_r15_wrt,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic [15:0] wb_r15_data,
    output logic        misalign
);
    localparam int DEPTH = 2 ** ADDR_W;

    // ex_valid=0 is a bubble: every enable is dropped at capture. There is no
    // backpressure; one instruction per cycle flows through with fixed latency.
    logic              r_exm_valid;
    logic [15:0]       r_exm_alu;
    logic [15:0]       r_exm_r15;
    logic [15:0]       r_exm_sd;
    logic [3:0]        r_exm_rd;
    logic              r_exm_reg_wrt;
    logic              r_exm_r15_wrt;
    logic              r_exm_mem_rd;
    logic              r_exm_mem_wrt;
    logic              r_exm_byte;

    logic              r_wb_reg_wrt;
    logic              r_wb_r15_wrt;
    logic [3:0]        r_wb_rd;
    logic [15:0]       r_wb_data;
    logic [15:0]       r_wb_r15_data;

    logic [7:0]        r_mem [0:DEPTH-1];

    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_a0;
    logic [ADDR_W-1:0] w_a1;
    logic              w_word_acc;
    logic              w_mis;
    logic              w_is_store;
    logic              w_is_load;
    logic [15:0]       w_rd_data;
    logic [15:0]       w_wb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exm_valid   <= 1'b0;
            r_exm_alu     <= 16'h0000;
            r_exm_r15     <= 16'h0000;
            r_exm_sd      <= 16'h0000;
            r_exm_rd      <= 4'h0;
            r_exm_reg_wrt <= 1'b0;
            r_exm_r15_wrt <= 1'b0;
            r_exm_mem_rd  <= 1'b0;
            r_exm_mem_wrt <= 1'b0;
            r_exm_byte    <= 1'b0;
        end else begin
            r_exm_valid   <= ex_valid;
            r_exm_alu     <= ex_alu_result;
            r_exm_r15     <= ex_r15_result;
            r_exm_sd      <= ex_store_data;
            r_exm_rd      <= ex_rd;
            r_exm_reg_wrt <= ex_valid & ex_reg_wrt;
            r_exm_r15_wrt <= ex_valid & ex_r15_wrt;
            r_exm_mem_rd  <= ex_valid & ex_mem_rd;
            r_exm_mem_wrt <= ex_valid & ex_mem_wrt;
            r_exm_byte    <= ex_byte;
        end
    end

    assign w_addr     = r_exm_alu[ADDR_W-1:0];
    assign w_word_acc = r_exm_valid & (r_exm_mem_rd | r_exm_mem_wrt) & ~r_exm_byte;

`ifdef MEMWB_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_mis = w_word_acc & w_addr[0];
    assign w_a0  = w_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_mis) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_mis    = 1'b0;
    assign w_a0     = w_word_acc ? {w_addr[ADDR_W-1:1], 1'b0} : w_addr;
    assign misalign = 1'b0;
`endif

    assign w_a1       = w_a0 + 1'b1;
    // A combined read+write request behaves purely as a store.
    assign w_is_store = r_exm_valid & r_exm_mem_wrt & ~w_mis;
    assign w_is_load  = r_exm_valid & r_exm_mem_rd & ~r_exm_mem_wrt;

    always_comb begin
        w_rd_data = 16'h0000;
        if (r_exm_byte) begin
            w_rd_data = {8'h00, r_mem[w_a0]};
        end else if (!w_mis) begin
            w_rd_data = {r_mem[w_a0], r_mem[w_a1]};
        end
        w_wb_data = w_is_load ? w_rd_data : r_exm_alu;
    end

    // Reset clears the whole array, so an in-flight store can never land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_is_store) begin
            if (r_exm_byte) begin
                r_mem[w_a0] <= r_exm_sd[7:0];
            end else begin
                r_mem[w_a0] <= r_exm_sd[15:8];
                r_mem[w_a1] <= r_exm_sd[7:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_reg_wrt  <= 1'b0;
            r_wb_r15_wrt  <= 1'b0;
            r_wb_rd       <= 4'h0;
            r_wb_data     <= 16'h0000;
            r_wb_r15_data <= 16'h0000;
        end else begin
            r_wb_reg_wrt  <= r_exm_reg_wrt;
            r_wb_r15_wrt  <= r_exm_r15_wrt;
            r_wb_rd       <= r_exm_rd;
            r_wb_data     <= w_wb_data;
            r_wb_r15_data <= r_exm_r15;
        end
    end

    assign exm_rd      = r_exm_rd;
    assign exm_reg_wrt = r_exm_reg_wrt;
    assign exm_result  = r_exm_alu;
    assign wb_reg_wrt  = r_wb_reg_wrt;
    assign wb_r15_wrt  = r_wb_r15_wrt;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign wb_r15_data = r_wb_r15_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: write-back results go through an expected queue
// stamped with the cycle they must appear in; side outputs are checked directly.
module tb_mem_wb_stage;
    localparam int W = 54;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_result;
    logic [15:0] ex_r15_result;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_rd;
    logic        ex_reg_wrt;
    logic        ex_r15_wrt;
    logic        ex_mem_rd;
    logic        ex_mem_wrt;
    logic        ex_byte;
    logic [3:0]  exm_rd;
    logic        exm_reg_wrt;
    logic [15:0] exm_result;
    logic        wb_reg_wrt;
    logic        wb_r15_wrt;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] wb_r15_data;
    logic        misalign;

    logic [W-1:0] exp_q[$];
    logic [15:0]  cyc;
    int           n_pass;
    int           n_total;

    mem_wb_stage #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_r15_result(ex_r15_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_wrt(ex_reg_wrt), .ex_r15_wrt(ex_r15_wrt),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wrt(ex_mem_wrt), .ex_byte(ex_byte),
        .exm_rd(exm_rd), .exm_reg_wrt(exm_reg_wrt), .exm_result(exm_result),
        .wb_reg_wrt(wb_reg_wrt), .wb_r15_wrt(wb_r15_wrt), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_r15_data(wb_r15_data), .misalign(misalign)
    );

    // clock / cycle stamp
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 16'd0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // monitor: every write-back must match the head of the queue, in its stamped cycle
    always @(negedge clk) begin
        if (!rst && (wb_reg_wrt || wb_r15_wrt)) begin
            logic [W-1:0] act;
            logic [W-1:0] exp;
            act = {cyc, wb_reg_wrt, wb_r15_wrt, wb_rd, wb_data, wb_r15_data};
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected actual=%h required=none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act === exp) n_pass++;
                else $display("FAIL wb_pop actual=%h required=%h", act, exp);
            end
        end
    end

    // driver tasks
    task automatic bubble_in();
        ex_valid = 1'b0; ex_alu_result = 16'h0; ex_r15_result = 16'h0;
        ex_store_data = 16'h0; ex_rd = 4'h0; ex_reg_wrt = 1'b0; ex_r15_wrt = 1'b0;
        ex_mem_rd = 1'b0; ex_mem_wrt = 1'b0; ex_byte = 1'b0;
    endtask

    task automatic idle(input int n);
        bubble_in();
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input logic [15:0] alu, input logic [15:0] r15, input logic [15:0] sd,
                         input logic [3:0] rd, input logic regw, input logic r15w,
                         input logic mrd, input logic mwrt, input logic byt,
                         input logic [15:0] exp_data, input bit push);
        ex_valid = 1'b1; ex_alu_result = alu; ex_r15_result = r15; ex_store_data = sd;
        ex_rd = rd; ex_reg_wrt = regw; ex_r15_wrt = r15w;
        ex_mem_rd = mrd; ex_mem_wrt = mwrt; ex_byte = byt;
        if (push && (regw || r15w))
            exp_q.push_back({cyc + 16'd2, regw, r15w, rd, exp_data, r15});
        @(posedge clk); #1;
    endtask

    task automatic load_w(input logic [15:0] a, input logic [3:0] rd, input logic [15:0] exp_data);
        issue(a, 16'h0, 16'h0, rd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, exp_data, 1'b1);
    endtask

    task automatic load_b(input logic [15:0] a, input logic [3:0] rd, input logic [15:0] exp_data);
        issue(a, 16'h0, 16'h0, rd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, exp_data, 1'b1);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d, input logic byt);
        issue(a, 16'h0, d, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, byt, 16'h0, 1'b1);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        bubble_in();
        rst = 1'b1;
        #1;
        check("rst_exm_rd", 32'(exm_rd), 32'h0);
        check("rst_exm_reg_wrt", 32'(exm_reg_wrt), 32'h0);
        check("rst_exm_result", 32'(exm_result), 32'h0);
        check("rst_wb_en", 32'({wb_reg_wrt, wb_r15_wrt}), 32'h0);
        check("rst_wb_data", 32'({wb_rd, wb_data, wb_r15_data}), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // bubble stream leaves everything at zero
        idle(3);
        check("bub_exm", 32'({exm_rd, exm_reg_wrt, exm_result}), 32'h0);
        check("bub_wb", 32'({wb_reg_wrt, wb_r15_wrt, wb_data}), 32'h0);

        // fresh memory reads zero
        load_w(16'h0040, 4'd1, 16'h0000);
        load_b(16'h0041, 4'd2, 16'h0000);

        // store then immediate load
        store(16'h0010, 16'hBEEF, 1'b0);
        load_w(16'h0010, 4'd4, 16'hBEEF);

        // byte store merges into the big-endian word
        store(16'h0011, 16'h1234, 1'b1);
        load_w(16'h0010, 4'd5, 16'hBE34);
        load_b(16'h0010, 4'd6, 16'h00BE);
        load_b(16'h0011, 4'd7, 16'h0034);
        load_w(16'hFF10, 4'd8, 16'hBE34);

        // ALU op with dual write; forwarding outputs in the following cycle
        issue(16'h0042, 16'h0007, 16'h0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b1);
        check("alu_exm_rd", 32'(exm_rd), 32'h3);
        check("alu_exm_result", 32'(exm_result), 32'h0042);
        check("alu_exm_reg_wrt", 32'(exm_reg_wrt), 32'h1);
        idle(1);

        // read+write together is a store; write-back carries the ALU result
        issue(16'h0030, 16'h0, 16'hA5A5, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0030, 1'b1);
        load_w(16'h0030, 4'd10, 16'hA5A5);

        // odd-address word store
        store(16'h0021, 16'h1357, 1'b0);
`ifdef MEMWB_MISALIGN_TRAP_EN
        load_w(16'h0020, 4'd11, 16'h0000);
        check("mis_flag", 32'(misalign), 32'h1);
        load_b(16'h0021, 4'd12, 16'h0000);
        load_w(16'h0021, 4'd13, 16'h0000);
`else
        load_w(16'h0020, 4'd11, 16'h1357);
        check("mis_flag", 32'(misalign), 32'h0);
        load_b(16'h0021, 4'd12, 16'h0057);
        load_w(16'h0021, 4'd13, 16'h1357);
`endif
        idle(4);
        check("drain_mid", 32'(exp_q.size()), 32'h0);

        // reset with a store in EX/MEM and a write-back in MEM/WB
        issue(16'h0077, 16'h0, 16'h0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        issue(16'h0050, 16'h0, 16'hCAFE, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        check("pre_rst_wb", 32'({wb_reg_wrt, exm_result}), 32'h10050);
        bubble_in();
        #1 rst = 1'b1;
        #1;
        check("arst_exm", 32'({exm_rd, exm_reg_wrt, exm_result}), 32'h0);
        check("arst_wb", 32'({wb_reg_wrt, wb_r15_wrt, wb_rd, wb_data}), 32'h0);
        check("arst_r15", 32'(wb_r15_data), 32'h0);
        check("arst_misalign", 32'(misalign), 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        load_w(16'h0050, 4'd1, 16'h0000);
        load_w(16'h0010, 4'd2, 16'h0000);
        load_w(16'h0030, 4'd3, 16'h0000);
        idle(4);
        check("drain_end", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the 16-bit pipelined CPU, directly downstream of the execute stage (ALU, swap and forward muxes). It latches execute-stage results into an EX/MEM register and performs byte or word load/store on a byte-addressed data memory. It then latches the outcome into a MEM/WB register that drives the register-file write ports, including the second R15 write port. It also exports EX/MEM destination and result for the forwarding unit.

## Interface
- `ADDR_W`, 8: data-memory byte-address width; memory holds 2^ADDR_W bytes.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ex_valid`  in  1  execute stage holds a real instruction; 0 = bubble.
- `ex_alu_result`  in  16  ALU result; also the memory address (low ADDR_W bits).
- `ex_r15_result`  in  16  R15 result (multiply high half / remainder).
- `ex_store_data`  in  16  data for stores.
- `ex_rd`  in  4  destination register of ALU/load result.
- `ex_reg_wrt`  in  1  write `ex_rd` in write-back.
- `ex_r15_wrt`  in  1  write R15 in write-back.
- `ex_mem_rd`, `ex_mem_wrt`  in  1 each  load / store.
- `ex_byte`  in  1  byte access (load byte / store byte); 0 = word.
- `exm_rd`  out  4  EX/MEM destination, to forwarding unit.
- `exm_reg_wrt`  out  1  EX/MEM valid and reg write.
- `exm_result`  out  16  EX/MEM ALU result.
- `wb_reg_wrt`, `wb_r15_wrt`  out  1 each  register-file write enables.
- `wb_rd`  out  4  write-back destination.
- `wb_data`  out  16  load data or ALU result.
- `wb_r15_data`  out  16  R15 write data.
- `misalign`  out  1  sticky misaligned-word-access flag.

## Operation
- EX/MEM register loads all `ex_*` inputs every edge. Bubbles (`ex_valid`=0) load with all enables forced to 0.
- Address a = EX/MEM `alu_result[ADDR_W-1:0]`. Upper bits are ignored.
- Memory is big-endian. A word at even a = {mem[a], mem[a+1]}.
- Load word: read data = {mem[a], mem[a+1]}.
- Load byte: read data = {8'h00, mem[a]} (zero-extended).
- Store word: mem[a] ← data[15:8], mem[a+1] ← data[7:0].
- Store byte: mem[a] ← data[7:0]; the other byte is untouched.
- Stores commit at the edge ending the MEM cycle, only when EX/MEM is valid.
- Read is combinational from EX/MEM state, so a load immediately following a store to the same address returns the stored value.
- `mem_rd` and `mem_wrt` both set: treat as a store only; `wb_data` = ALU result.
- MEM/WB register loads:
  - `wb_data` = read data if `mem_rd`, else ALU result.
  - `wb_r15_data` = R15 result.
  - `wb_rd` and both write enables pass through.
- `wb_reg_wrt` and `wb_r15_wrt` may be asserted together (swap / multiply). Register-file ordering is owned by the register file.
- Reset: all EX/MEM and MEM/WB fields and outputs go to 0, `misalign` clears, and every memory byte clears to 8'h00. Reset mid-operation discards in-flight instructions; no partial store occurs.

## Timing
- Instruction in EX during cycle N:
  - captured in EX/MEM at edge N+1;
  - memory access during cycle N+1; store commit and MEM/WB capture at edge N+2;
  - write-back outputs valid during cycle N+2.
- `exm_*` valid during cycle N+1.
- Latency is fixed at 2 cycles. There is no stall input; the upstream sends bubbles.

## Configuration
- `MEMWB_MISALIGN_TRAP_EN` defined: a word access at odd a sets `misalign` (sticky until reset). A misaligned store is suppressed. A misaligned load returns 16'h0000 and still writes back.
- Undefined: the address is silently aligned down (a & ~1), and `misalign` is tied 0.

## Test plan
- Reset, then a bubble stream: all outputs 0. A load of any address returns 16'h0000.
- Store word 16'hBEEF @0x10, then load word @0x10 next cycle: `wb_data` = 16'hBEEF two cycles after the load enters EX, with `wb_reg_wrt`=1.
- Store byte 16'h1234 @0x11 over the previous word, then load word @0x10 → 16'hBE34. Load byte @0x10 → 16'h00BE.
- ALU op: result 16'h0042, R15 16'h0007, rd=3, both write enables set → `exm_rd`=3 and `exm_result`=16'h0042 in cycle N+1. `wb_data`=16'h0042 and `wb_r15_data`=16'h0007 in cycle N+2.
- Store word @0x21 → with the macro: `misalign`=1 and mem[0x20..0x21] unchanged. Without the macro: the word is written to 0x20.
- Assert `rst` while a store sits in EX/MEM: no memory write; all outputs are 0 immediately, asynchronously.
